camera_stream_emulator: RTL and testbench
=========================================

Name: camera_stream_emulator

Overview:
Synthetic image sensor that drives the same pixel-bus protocol the camera data capture path consumes: PIXCLK, 10-bit Bayer data, FVAL and LVAL. It replaces the physical camera on the GPIO_1 header path, either through a top-level mux or in simulation. This lets the capture, SDRAM and filter pipeline be exercised with known, deterministic frames. It is the transmitter end of the camera pixel interface.

Parameters:
H_ACTIVE, 1280, active pixels per line (LVAL high); must be ≥2 and even
H_BLANK, 64, pixels per line with LVAL low, between lines
V_ACTIVE, 960, active lines per frame; must be ≥2 and even
V_BLANK, 16, line-periods (H_ACTIVE+H_BLANK pixels each) with FVAL low, between frames
FV_LEAD, 4, pixels with FVAL high before the first LVAL of a frame
FV_TRAIL, 4, pixels with FVAL high after the last LVAL of a frame

Ports:
Clock  in  1  50 MHz system clock
Resetn  in  1  asynchronous, active-low reset
Enable  in  1  level; low aborts immediately and idles the bus
Start  in  1  level/pulse; request continuous frame generation
Stop  in  1  level/pulse; finish current frame, then idle
Pattern_sel  in  2  0 h-ramp, 1 v-ramp, 2 colour bars, 3 frame-count solid
oPIXCLK  out  1  pixel clock, Clock/2
oData  out  10  Bayer pixel data
oFVAL  out  1  frame valid
oLVAL  out  1  line valid
oFrame_Count  out  32  completed frames
oBusy  out  1  high while a frame is in progress or pending

Behaviour:
- Reset: all outputs 0, state IDLE, run/pending flags cleared.
- oPIXCLK toggles every Clock while Enable=1; it is held 0 while Enable=0.
- A pixel step is a Clock edge where oPIXCLK goes 1→0. oData, oFVAL and oLVAL change only on pixel steps, so they are stable across the rising PIXCLK edge, with one Clock of setup and one of hold.
- Start while IDLE and Enable=1 sets run. The frame begins at the next pixel step: oFVAL=1 and state LEAD. oBusy=1 from the cycle after Start.
- States, counted in pixel steps:
  - IDLE
  - LEAD: FV_LEAD steps → ACTIVE
  - ACTIVE: H_ACTIVE steps with LVAL=1. Then HBLANK, or TRAIL if the current line is the last (V_ACTIVE-1).
  - HBLANK: H_BLANK steps, LVAL=0, FVAL=1 → ACTIVE with line+1
  - TRAIL: FV_TRAIL steps → VBLANK. On entering VBLANK, FVAL=0 and oFrame_Count increments (wraps at 2^32).
  - VBLANK: V_BLANK·(H_ACTIVE+H_BLANK) steps. Then LEAD if run=1, else IDLE with oBusy=0.
- Stop clears run at any time; the current frame always completes. Start and Stop in the same cycle: Stop wins.
- Start during a frame while run=1 has no effect. Start after a Stop, before IDLE is reached, re-sets run and continues without a gap.
- Enable falls: the next Clock goes to IDLE, all outputs go to 0, run clears and the frame count is held. A partial frame is not counted.
- Pattern_sel is latched at LEAD entry and is constant for the whole frame.
- oData is 0 whenever LVAL=0. With x the pixel index in the line and y the line index (10/11-bit counters):
  - mode 0: x[9:0]
  - mode 1: y[9:0]
  - mode 2: bar b = x[9:7]; R=b[2], G=b[1], B=b[0]. The Bayer site selects the channel: (y[0],x[0]) = (0,0) G, (0,1) R, (1,0) B, (1,1) G. Output is 10'h3FF if that channel is set, else 0.
  - mode 3: {frame_count_latched[7:0], 2'b00}, frame count latched at LEAD entry.
- oData is registered. The pattern value for pixel x is presented in the same pixel step that LVAL is high for x.

Decomposition:
- Package camera_emu_pkg:
  - state enum (IDLE, LEAD, ACTIVE, HBLANK, TRAIL, VBLANK)
  - pattern enum (PAT_HRAMP, PAT_VRAMP, PAT_BARS, PAT_FCOUNT)
  - Bayer site constants
- Sub-module camera_emu_pattern: combinational function of (mode, x, y, frame latch) → 10-bit data.
- The top keeps the timing FSM, counters, PIXCLK divider and output registers.

Test Plan:
(All scenarios use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, V_BLANK=2, FV_LEAD=2, FV_TRAIL=2.)
1. Reset, Enable=1, pulse Start, mode 0 → FVAL high for 48 pixel steps. 4 LVAL bursts of 8 steps, gaps of 4. oData in each burst = 0..7. FVAL low 24 steps. Frame period 144 Clocks. oFrame_Count=1 at the first FVAL fall.
2. Mode 2, first two lines → line 0 data = G,R alternating with bar 0: 0,0,0,0,0,0,0,0. Repeat with H_ACTIVE=256 and check that x=128..255 (bar 1, B only) on line 1 gives B sites = 3FF and G sites = 0.
3. Pulse Stop mid-frame 1 → frame 1 completes, oFrame_Count=1, oBusy falls at the end of VBLANK, no second FVAL rise.
4. Drop Enable mid-ACTIVE → next Clock: oFVAL=oLVAL=oData=oPIXCLK=0, oBusy=0, oFrame_Count unchanged (0).
5. Start and Stop asserted together in IDLE → no FVAL ever rises and oBusy stays 0. Change Pattern_sel mid-frame → data keeps the old pattern until the next LEAD.
6. Protocol checker throughout: oData, oFVAL and oLVAL never change on a Clock where oPIXCLK rises. LVAL is never high while FVAL is low.

Source files
------------

// File: rtl/camera_emu_pkg.sv
// rtl/camera_emu_pkg.sv - shared types and Bayer site codes for the camera stream emulator
package camera_emu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        ACTIVE,
        HBLANK,
        TRAIL,
        VBLANK
    } state_e;

    typedef enum logic [1:0] {
        PAT_HRAMP,
        PAT_VRAMP,
        PAT_BARS,
        PAT_FCOUNT
    } pattern_e;

    // Bayer site index is {y[0], x[0]}
    localparam logic [1:0] SITE_G_EVEN = 2'b00;
    localparam logic [1:0] SITE_R      = 2'b01;
    localparam logic [1:0] SITE_B      = 2'b10;
    localparam logic [1:0] SITE_G_ODD  = 2'b11;

endpackage

// File: rtl/camera_emu_pattern.sv
// rtl/camera_emu_pattern.sv - combinational test-pattern generator for one Bayer pixel
module camera_emu_pattern
    import camera_emu_pkg::*;
(
    input  logic [1:0] mode_i,
    input  logic [9:0] x_i,
    input  logic [9:0] y_i,
    input  logic [7:0] frame_i,
    output logic [9:0] data_o
);

    logic [2:0] bar;
    logic       chan_on;

    assign bar = x_i[9:7];

    // Bar index bits are {R, G, B}; the Bayer site picks which one is visible
    always_comb begin
        chan_on = 1'b0;
        case ({y_i[0], x_i[0]})
            SITE_R:      chan_on = bar[2];
            SITE_B:      chan_on = bar[0];
            SITE_G_EVEN: chan_on = bar[1];
            SITE_G_ODD:  chan_on = bar[1];
        endcase
    end

    always_comb begin
        data_o = '0;
        case (mode_i)
            PAT_HRAMP:  data_o = x_i;
            PAT_VRAMP:  data_o = y_i;
            PAT_BARS:   data_o = {10{chan_on}};
            PAT_FCOUNT: data_o = {frame_i, 2'b00};
        endcase
    end

endmodule

// File: rtl/camera_stream_emulator.sv
// rtl/camera_stream_emulator.sv - synthetic Bayer camera: frame timing FSM, PIXCLK divider, registered pixel bus
module camera_stream_emulator
    import camera_emu_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int H_BLANK  = 64,
    parameter int V_ACTIVE = 960,
    parameter int V_BLANK  = 16,
    parameter int FV_LEAD  = 4,
    parameter int FV_TRAIL = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    input  logic        Start,
    input  logic        Stop,
    input  logic [1:0]  Pattern_sel,
    output logic        oPIXCLK,
    output logic [9:0]  oData,
    output logic        oFVAL,
    output logic        oLVAL,
    output logic [31:0] oFrame_Count,
    output logic        oBusy
);

    localparam int LINE_STEPS   = H_ACTIVE + H_BLANK;
    localparam int VBLANK_STEPS = V_BLANK * LINE_STEPS;
    localparam int CW           = 24;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [10:0]   line_q, line_d;
    logic [1:0]    mode_q, mode_d;
    logic [7:0]    fcl_q, fcl_d;
    logic          run_q, run_d;
    logic          pclk_q;
    logic          fval_q, lval_q, busy_q;
    logic [9:0]    data_q, pat_data;
    logic [31:0]   frame_count_q;

    assign run_d = Stop ? 1'b0 : (Start | run_q);

    // pclk_q high means this Clock edge is a pixel step (PIXCLK falls)
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        line_d  = line_q;
        mode_d  = mode_q;
        fcl_d   = fcl_q;
        if (pclk_q) begin
            cnt_d = cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (run_q) state_d = LEAD;
                end
                LEAD: if (cnt_q == CW'(FV_LEAD - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    line_d  = '0;
                end
                ACTIVE: if (cnt_q == CW'(H_ACTIVE - 1)) begin
                    state_d = (line_q == 11'(V_ACTIVE - 1)) ? TRAIL : HBLANK;
                    cnt_d   = '0;
                end
                HBLANK: if (cnt_q == CW'(H_BLANK - 1)) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                    line_d  = line_q + 1'b1;
                end
                TRAIL: if (cnt_q == CW'(FV_TRAIL - 1)) begin
                    state_d = VBLANK;
                    cnt_d   = '0;
                end
                VBLANK: if (cnt_q == CW'(VBLANK_STEPS - 1)) begin
                    state_d = run_q ? LEAD : IDLE;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
            if (state_d == LEAD && state_q != LEAD) begin
                mode_d = Pattern_sel;
                fcl_d  = frame_count_q[7:0];
            end
        end
    end

    camera_emu_pattern u_pattern (
        .mode_i  (mode_d),
        .x_i     (cnt_d[9:0]),
        .y_i     (line_d[9:0]),
        .frame_i (fcl_d),
        .data_o  (pat_data)
    );

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            line_q        <= '0;
            mode_q        <= '0;
            fcl_q         <= '0;
            run_q         <= 1'b0;
            pclk_q        <= 1'b0;
            fval_q        <= 1'b0;
            lval_q        <= 1'b0;
            data_q        <= '0;
            busy_q        <= 1'b0;
            frame_count_q <= '0;
        end else if (!Enable) begin
            // Abort: partial frame is dropped, frame count is kept
            state_q <= IDLE;
            cnt_q   <= '0;
            line_q  <= '0;
            run_q   <= 1'b0;
            pclk_q  <= 1'b0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            data_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            line_q  <= line_d;
            mode_q  <= mode_d;
            fcl_q   <= fcl_d;
            run_q   <= run_d;
            pclk_q  <= ~pclk_q;
            busy_q  <= run_d | (state_d != IDLE);
            if (pclk_q) begin
                fval_q <= (state_d != IDLE) && (state_d != VBLANK);
                lval_q <= (state_d == ACTIVE);
                data_q <= (state_d == ACTIVE) ? pat_data : '0;
                if (state_q == TRAIL && state_d == VBLANK)
                    frame_count_q <= frame_count_q + 32'd1;
            end
        end
    end

    assign oPIXCLK      = pclk_q;
    assign oData        = data_q;
    assign oFVAL        = fval_q;
    assign oLVAL        = lval_q;
    assign oFrame_Count = frame_count_q;
    assign oBusy        = busy_q;

endmodule

// File: tb/tb_camera_stream_emulator.sv
// tb/tb_camera_stream_emulator.sv - self-checking bench for camera_stream_emulator
module tb_camera_stream_emulator;

    localparam int HA = 8, HB = 4, VA = 4, VB = 2, FL = 2, FT = 2;
    localparam int LINE     = HA + HB;
    localparam int FV_STEPS = FL + VA * LINE - HB + FT;
    localparam int PERIOD   = FV_STEPS + VB * LINE;

    logic        Clock = 1'b0, Resetn = 1'b0, Enable = 1'b0, Start = 1'b0, Stop = 1'b0;
    logic [1:0]  Pattern_sel = 2'd0;
    logic        oPIXCLK, oFVAL, oLVAL, oBusy;
    logic [9:0]  oData;
    logic [31:0] oFrame_Count;

    logic        b_en = 1'b0, b_start = 1'b0, b_stop = 1'b0;
    logic        b_pclk, b_fval, b_lval, b_busy;
    logic [9:0]  b_data;
    logic [31:0] b_fc;

    logic [1:0]  p_mode;
    logic [9:0]  p_x, p_y, p_data;
    logic [7:0]  p_fc;

    int total = 0, bad = 0;

    always #10 Clock = ~Clock;

    camera_stream_emulator #(.H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                             .FV_LEAD(FL), .FV_TRAIL(FT)) dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable), .Start(Start), .Stop(Stop),
        .Pattern_sel(Pattern_sel), .oPIXCLK(oPIXCLK), .oData(oData), .oFVAL(oFVAL),
        .oLVAL(oLVAL), .oFrame_Count(oFrame_Count), .oBusy(oBusy));

    camera_stream_emulator #(.H_ACTIVE(256), .H_BLANK(HB), .V_ACTIVE(VA), .V_BLANK(VB),
                             .FV_LEAD(FL), .FV_TRAIL(FT)) dut_b (
        .Clock(Clock), .Resetn(Resetn), .Enable(b_en), .Start(b_start), .Stop(b_stop),
        .Pattern_sel(2'd2), .oPIXCLK(b_pclk), .oData(b_data), .oFVAL(b_fval),
        .oLVAL(b_lval), .oFrame_Count(b_fc), .oBusy(b_busy));

    camera_emu_pattern u_pat (
        .mode_i(p_mode), .x_i(p_x), .y_i(p_y), .frame_i(p_fc), .data_o(p_data));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] pat_ref(input int mode, input int x, input int y, input int fc);
        int  b;
        bit  on;
        b = (x / 128) % 8;
        if (y % 2 == 0 && x % 2 == 1)      on = (b / 4) % 2 == 1;
        else if (y % 2 == 1 && x % 2 == 0) on = b % 2 == 1;
        else                               on = (b / 2) % 2 == 1;
        case (mode)
            0:       return 10'(x % 1024);
            1:       return 10'(y % 1024);
            2:       return on ? 10'h3FF : 10'h000;
            default: return 10'((fc % 256) * 4);
        endcase
    endfunction

    // Reference: a single position-in-frame counter, -1 when no frame is running
    int          m_pos = -1, m_mode = 0, m_fcl = 0;
    logic [31:0] m_fc = '0;
    logic        m_run = 1'b0, m_pclk = 1'b0;

    always @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            m_pos = -1; m_mode = 0; m_fcl = 0; m_fc = '0; m_run = 1'b0; m_pclk = 1'b0;
        end else if (!Enable) begin
            m_pos = -1; m_run = 1'b0; m_pclk = 1'b0;
        end else begin
            if (m_pclk) begin
                if (m_pos < 0 || m_pos == PERIOD - 1) begin
                    if (m_run) begin
                        m_pos = 0; m_mode = int'(Pattern_sel); m_fcl = int'(m_fc[7:0]);
                    end else begin
                        m_pos = -1;
                    end
                end else begin
                    m_pos++;
                    if (m_pos == FV_STEPS) m_fc = m_fc + 32'd1;
                end
            end
            m_pclk = ~m_pclk;
            if (Stop) m_run = 1'b0;
            else if (Start) m_run = 1'b1;
        end
    end

    function automatic logic [11:0] exp_bus(input int pos, input int mode, input int fcl);
        int   j, ln, x;
        logic fv, lv;
        fv = pos >= 0 && pos < FV_STEPS;
        j  = pos - FL;
        ln = (j >= 0) ? j / LINE : 0;
        x  = (j >= 0) ? j % LINE : 0;
        lv = fv && j >= 0 && j < VA * LINE - HB && x < HA;
        return {fv, lv, lv ? pat_ref(mode, x, ln, fcl) : 10'd0};
    endfunction

    logic [11:0] e_bus;
    logic        p_pclk = 1'b0, p_fv = 1'b0, p_lv = 1'b0;
    logic [11:0] p_out = '0;
    int          fval_rises = 0, lval_rises = 0;

    always @(negedge Clock) begin
        if (Resetn) begin
            e_bus = exp_bus(m_pos, m_mode, m_fcl);
            check("model", 64'({oPIXCLK, oFVAL, oLVAL, oData, oBusy, oFrame_Count}),
                  64'({m_pclk, e_bus, m_run | (m_pos >= 0), m_fc}));
            if (!p_pclk && oPIXCLK) check("hold_at_pixclk_rise", 64'({oFVAL, oLVAL, oData}), 64'(p_out));
            check("lval_outside_fval", 64'(oLVAL & ~oFVAL), 64'(0));
            if (oFVAL && !p_fv) fval_rises++;
            if (oLVAL && !p_lv) lval_rises++;
        end
        p_pclk = oPIXCLK; p_fv = oFVAL; p_lv = oLVAL;
        p_out  = {oFVAL, oLVAL, oData};
    end

    task automatic wait_for(input string name, input int sel, input logic val,
                            input int budget, output int n);
        logic s;
        n = 0;
        forever begin
            s = (sel == 0) ? oFVAL : (sel == 1) ? oLVAL : oBusy;
            if (s === val || n >= budget) break;
            @(negedge Clock);
            n++;
        end
        if (s !== val) begin
            total++; bad++;
            $display("FAIL %s: timeout after %0d clocks", name, n);
        end
    endtask

    task automatic pulse(input bit do_start, input bit do_stop);
        Start = do_start; Stop = do_stop;
        @(negedge Clock);
        Start = 1'b0; Stop = 1'b0;
    endtask

    typedef struct {
        logic [1:0] mode;
        logic [9:0] x;
        logic [9:0] y;
        logic [7:0] fc;
        logic [9:0] exp;
    } pat_vec_t;

    pat_vec_t    tbl[12];
    int          n, lr0, fr0, xi, line_n, off;
    logic        pp, pl, busy_seen;
    logic [9:0]  cap [2][256];
    int          lens[2];

    initial begin
        tbl[0]  = '{2'd0, 10'd5,   10'd3,   8'd0,    10'd5};
        tbl[1]  = '{2'd0, 10'd1023,10'd0,   8'd0,    10'd1023};
        tbl[2]  = '{2'd1, 10'd7,   10'd513, 8'd0,    10'd513};
        tbl[3]  = '{2'd2, 10'd0,   10'd0,   8'd0,    10'h000};
        tbl[4]  = '{2'd2, 10'd128, 10'd1,   8'd0,    10'h3FF};
        tbl[5]  = '{2'd2, 10'd129, 10'd1,   8'd0,    10'h000};
        tbl[6]  = '{2'd2, 10'd256, 10'd0,   8'd0,    10'h3FF};
        tbl[7]  = '{2'd2, 10'd257, 10'd0,   8'd0,    10'h000};
        tbl[8]  = '{2'd2, 10'd513, 10'd0,   8'd0,    10'h3FF};
        tbl[9]  = '{2'd2, 10'd896, 10'd1,   8'd0,    10'h3FF};
        tbl[10] = '{2'd2, 10'd640, 10'd0,   8'd0,    10'h000};
        tbl[11] = '{2'd3, 10'd9,   10'd2,   8'hA5,   10'h294};
        for (int i = 0; i < 12; i++) begin
            p_mode = tbl[i].mode; p_x = tbl[i].x; p_y = tbl[i].y; p_fc = tbl[i].fc;
            #1;
            check($sformatf("pattern[%0d]", i), 64'(p_data), 64'(tbl[i].exp));
        end

        repeat (3) @(negedge Clock);
        check("reset_outputs", 64'({oPIXCLK, oFVAL, oLVAL, oData, oBusy, oFrame_Count}), 64'(0));
        Resetn = 1'b1; Enable = 1'b1; Pattern_sel = 2'd0;
        repeat (4) @(negedge Clock);

        // Continuous frames, mode 0
        pulse(1'b1, 1'b0);
        check("busy_after_start", 64'(oBusy), 64'(1));
        wait_for("fval_rise1", 0, 1'b1, 20, n);
        lr0 = lval_rises;
        wait_for("fval_fall1", 0, 1'b0, 400, n);
        check("fval_high_clocks", 64'(n), 64'(2 * FV_STEPS));
        check("frame_count_1", 64'(oFrame_Count), 64'(1));
        check("lval_bursts", 64'(lval_rises - lr0), 64'(VA));
        wait_for("fval_rise2", 0, 1'b1, 400, n);
        check("fval_low_clocks", 64'(n), 64'(2 * (PERIOD - FV_STEPS)));

        // Stop mid-frame: frame finishes, then idle
        repeat (20) @(negedge Clock);
        pulse(1'b0, 1'b1);
        wait_for("fval_fall2", 0, 1'b0, 400, n);
        check("frame_count_2", 64'(oFrame_Count), 64'(2));
        wait_for("busy_fall", 2, 1'b0, 400, n);
        check("busy_fall_clocks", 64'(n), 64'(2 * (PERIOD - FV_STEPS)));
        fr0 = fval_rises;
        repeat (300) @(negedge Clock);
        check("no_frame_after_stop", 64'(fval_rises - fr0), 64'(0));

        // Stop then Start inside a frame; pattern change mid-frame
        Pattern_sel = 2'd1;
        pulse(1'b1, 1'b0);
        wait_for("fval_rise3", 0, 1'b1, 20, n);
        repeat (10) @(negedge Clock);
        pulse(1'b0, 1'b1);
        repeat (10) @(negedge Clock);
        Pattern_sel = 2'd2;
        pulse(1'b1, 1'b0);
        wait_for("fval_fall3", 0, 1'b0, 400, n);
        wait_for("fval_rise4", 0, 1'b1, 400, n);
        check("restart_gap_clocks", 64'(n), 64'(2 * (PERIOD - FV_STEPS)));

        // Enable drop mid-ACTIVE
        wait_for("lval_rise4", 1, 1'b1, 100, n);
        repeat (3) @(negedge Clock);
        Enable = 1'b0;
        @(negedge Clock);
        check("abort_outputs", 64'({oPIXCLK, oFVAL, oLVAL, oData, oBusy}), 64'(0));
        check("abort_frame_count", 64'(oFrame_Count), 64'(3));
        repeat (5) @(negedge Clock);
        Enable = 1'b1;
        repeat (4) @(negedge Clock);

        // Start and Stop together in IDLE
        fr0 = fval_rises;
        busy_seen = 1'b0;
        pulse(1'b1, 1'b1);
        for (int i = 0; i < 300; i++) begin
            busy_seen = busy_seen | oBusy;
            @(negedge Clock);
        end
        check("start_stop_busy", 64'(busy_seen), 64'(0));
        check("start_stop_no_frame", 64'(fval_rises - fr0), 64'(0));

        // Frame-count pattern uses the count latched at LEAD
        Pattern_sel = 2'd3;
        pulse(1'b1, 1'b0);
        wait_for("lval_mode3", 1, 1'b1, 100, n);
        check("mode3_data", 64'(oData), 64'(12));
        pulse(1'b0, 1'b1);
        wait_for("busy_fall_mode3", 2, 1'b0, 400, n);

        // Wide-line colour bars on the second instance
        b_en = 1'b1;
        @(negedge Clock);
        b_start = 1'b1; @(negedge Clock); b_start = 1'b0;
        xi = 0; line_n = 0; pp = 1'b0; pl = 1'b0; lens = '{0, 0};
        for (int r = 0; r < 2; r++) for (int c = 0; c < 256; c++) cap[r][c] = 10'h155;
        for (int c = 0; c < 4000 && line_n < 2; c++) begin
            @(negedge Clock);
            if (pp && !b_pclk) begin
                if (b_lval) begin
                    if (xi < 256) cap[line_n][xi] = b_data;
                    xi++;
                end else if (pl) begin
                    lens[line_n] = xi; xi = 0; line_n++;
                end
                pl = b_lval;
            end
            pp = b_pclk;
        end
        check("bars_lines_seen", 64'(line_n), 64'(2));
        for (int r = 0; r < 2; r++) begin
            check($sformatf("bars_len[%0d]", r), 64'(lens[r]), 64'(256));
            for (int c = 0; c < 256; c++)
                check($sformatf("bars[%0d][%0d]", r, c), 64'(cap[r][c]), 64'(pat_ref(2, c, r, 0)));
        end
        b_stop = 1'b1; @(negedge Clock); b_stop = 1'b0; b_en = 1'b0;

        // Random control traffic against the reference model
        off = 0;
        for (int c = 0; c < 6000; c++) begin
            Start = ($urandom % 40) == 0;
            Stop  = ($urandom % 400) == 0;
            if (($urandom % 64) == 0) Pattern_sel = 2'($urandom);
            if (off > 0) begin
                off--;
                Enable = (off == 0);
            end else if (($urandom % 1500) == 0) begin
                Enable = 1'b0;
                off = $urandom_range(1, 6);
            end
            @(negedge Clock);
        end
        Start = 1'b0; Stop = 1'b0; Enable = 1'b1;
        repeat (4) @(negedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
